// File: rtl/data_pkg.sv
// data_pkg: shared FSM state type and frame constants for the telemetry link block
package data_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MEAS = 3'd1,
        TX   = 3'd2,
        RX   = 3'd3,
        ADJ  = 3'd4
    } state_t;
    localparam logic [7:0] PREAMBLE   = 8'hA5;
    localparam int         FRAME_BITS = 152;
    localparam int         RX_BITS    = 16;
endpackage

// File: rtl/data_bit_rx.sv
// data_bit_rx: majority-vote sampler deciding one received bit per BIT_CYCLES window
module data_bit_rx #(
    parameter int BIT_CYCLES = 1000
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic start,
    input  logic above,
    output logic bit_o,
    output logic valid
);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    logic          busy;
    logic [CW-1:0] cnt, hits, cnt_e, hits_e, sum;
    assign cnt_e  = start ? '0 : cnt;
    assign hits_e = start ? '0 : hits;
    assign sum    = hits_e + CW'(above);
    assign valid  = (start || busy) && cnt_e == CW'(BIT_CYCLES - 1);
    assign bit_o  = sum > CW'(BIT_CYCLES / 2);
    // accumulate above-threshold samples across the window, restart on each window start
    always_ff @(posedge clk) begin
        if (!nrst || clr) begin
            busy <= 1'b0;
            cnt  <= '0;
            hits <= '0;
        end else if (start || busy) begin
            busy <= !valid;
            cnt  <= valid ? '0 : cnt_e + 1'b1;
            hits <= valid ? '0 : sum;
        end
    end
endmodule

// File: rtl/data.sv
// data: measure, transmit telemetry frame, receive two feedback bytes, strobe duty adjust
module data
    import data_pkg::*;
#(
    parameter int         BIT_CYCLES   = 1000,
    parameter int         MEAS_CYCLES  = 2000,
    parameter logic [7:0] POWER_TARGET = 8'h80
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    // top-level phase selector; the block runs only in phase 2'b11
    input  logic [1:0]  prog,
    input  logic [11:0] ADC,
    input  logic [11:0] meanCurrent,
    input  logic [15:0] SWIPT_P_TX,
    input  logic [15:0] SWIPT_DUTY,
    input  logic [15:0] SWIPT_FREQ,
    input  logic [15:0] SWIPT_ASCII,
    input  logic [15:0] ANC_MAX_HEIGHT,
    input  logic [15:0] ANC_MIN_HEIGHT,
    input  logic [15:0] COMMS_TRAJECT,
    input  logic [15:0] COMMS_QR_CODES,
    input  logic [15:0] COMMS_FLIGHT_TIME,
    output logic [7:0]  RECEIVED_EFF,
    output logic [7:0]  RECEIVED_POWER_RX,
    output logic        read,
    output logic        write,
    output logic        dout,
    output logic        l_rdy,
    output logic        l_up_down,
    output logic        getMeanCurrent
);
    localparam int CMAX = (MEAS_CYCLES > BIT_CYCLES) ? MEAS_CYCLES : BIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [7:0]            bidx;
    logic [FRAME_BITS-1:0] frame;
    logic [RX_BITS-1:0]    rx_sr, rx_word;
    logic                  active, bit_end, meas_end, tx_last, rx_last, rx_bit, rx_valid;
    assign active         = prog == 2'b11 && swiptAlive;
    assign bit_end        = cnt == CW'(BIT_CYCLES - 1);
    assign meas_end       = cnt == CW'(MEAS_CYCLES - 1);
    assign tx_last        = bidx == 8'(FRAME_BITS - 1);
    assign rx_last        = bidx == 8'(RX_BITS - 1);
    assign rx_word        = {rx_sr[RX_BITS-2:0], rx_bit};
    assign read           = state == RX;
    assign write          = state == TX;
    assign dout           = write && frame[FRAME_BITS-1];
    assign getMeanCurrent = state == MEAS;
    assign l_rdy          = state == ADJ;
    assign l_up_down      = l_rdy && RECEIVED_POWER_RX > POWER_TARGET;

    data_bit_rx #(.BIT_CYCLES(BIT_CYCLES)) u_bit_rx (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (!active || state != RX),
        .start (state == RX && cnt == '0),
        .above (ADC > meanCurrent),
        .bit_o (rx_bit),
        .valid (rx_valid)
    );

    // phase sequencing; losing the link or phase drops to IDLE but keeps the last received bytes
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state             <= IDLE;
            cnt               <= '0;
            bidx              <= '0;
            frame             <= '0;
            rx_sr             <= '0;
            RECEIVED_EFF      <= '0;
            RECEIVED_POWER_RX <= '0;
        end else if (!active) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            frame <= '0;
            rx_sr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= MEAS;
                    cnt   <= '0;
                end
                MEAS: begin
                    cnt <= meas_end ? '0 : cnt + 1'b1;
                    if (meas_end) begin
                        state <= TX;
                        frame <= {PREAMBLE, SWIPT_P_TX, SWIPT_DUTY, SWIPT_FREQ, SWIPT_ASCII,
                                  ANC_MAX_HEIGHT, ANC_MIN_HEIGHT, COMMS_TRAJECT,
                                  COMMS_QR_CODES, COMMS_FLIGHT_TIME};
                    end
                end
                TX: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        frame <= frame << 1;
                        bidx  <= tx_last ? '0 : bidx + 1'b1;
                        if (tx_last) state <= RX;
                    end
                end
                RX: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (rx_valid) begin
                        rx_sr <= rx_last ? '0 : rx_word;
                        bidx  <= rx_last ? '0 : bidx + 1'b1;
                        if (rx_last) begin
                            state             <= ADJ;
                            RECEIVED_EFF      <= rx_word[15:8];
                            RECEIVED_POWER_RX <= rx_word[7:0];
                        end
                    end
                end
                default: begin
                    state <= MEAS;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data.sv
// tb_data: scoreboard bench for the telemetry link block
module tb_data;
    localparam int BC = 4;
    localparam int MC = 8;
    logic        clk = 1'b0, nrst = 1'b0, swiptAlive = 1'b0;
    logic [1:0]  prog = 2'b00;
    logic [11:0] ADC = '0, meanCurrent = 12'h800;
    logic [15:0] w [9];
    logic [7:0]  RECEIVED_EFF, RECEIVED_POWER_RX;
    logic        read, write, dout, l_rdy, l_up_down, getMeanCurrent;
    int          errors = 0, checks = 0;
    int          q_meas[$], q_write[$], q_read[$];
    logic        q_bits[$];
    logic [16:0] q_adj[$];
    int          len_m = 0, len_w = 0, len_r = 0, wpos = 0;
    logic        cur = 1'b0;
    logic [16:0] e_adj;
    logic [11:0] p1a[4] = '{12'hA00, 12'hA00, 12'hA00, 12'hA00};
    logic [11:0] p1b[4] = '{12'hA00, 12'h800, 12'hA00, 12'hA00};
    logic [11:0] p0a[4] = '{12'h600, 12'h600, 12'h600, 12'h600};
    logic [11:0] p0b[4] = '{12'hA00, 12'h600, 12'hA00, 12'h800};

    always #5 clk = ~clk;

    data #(.BIT_CYCLES(BC), .MEAS_CYCLES(MC), .POWER_TARGET(8'h80)) dut (
        .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .prog(prog), .ADC(ADC),
        .meanCurrent(meanCurrent), .SWIPT_P_TX(w[0]), .SWIPT_DUTY(w[1]), .SWIPT_FREQ(w[2]),
        .SWIPT_ASCII(w[3]), .ANC_MAX_HEIGHT(w[4]), .ANC_MIN_HEIGHT(w[5]),
        .COMMS_TRAJECT(w[6]), .COMMS_QR_CODES(w[7]), .COMMS_FLIGHT_TIME(w[8]),
        .RECEIVED_EFF(RECEIVED_EFF), .RECEIVED_POWER_RX(RECEIVED_POWER_RX),
        .read(read), .write(write), .dout(dout), .l_rdy(l_rdy), .l_up_down(l_up_down),
        .getMeanCurrent(getMeanCurrent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input int v);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event value %0d, nothing expected", name, v);
    endtask

    // monitor: window lengths, transmitted bits and adjust strobes against queued expectations
    always @(negedge clk) begin
        if (getMeanCurrent) len_m++;
        else if (len_m > 0) begin
            if (q_meas.size() == 0) miss("meas_len", len_m);
            else chk("meas_len", 32'(len_m), 32'(q_meas.pop_front()));
            len_m = 0;
        end
        if (write) len_w++;
        else if (len_w > 0) begin
            if (q_write.size() == 0) miss("write_len", len_w);
            else chk("write_len", 32'(len_w), 32'(q_write.pop_front()));
            len_w = 0;
        end
        if (read) len_r++;
        else if (len_r > 0) begin
            if (q_read.size() == 0) miss("read_len", len_r);
            else chk("read_len", 32'(len_r), 32'(q_read.pop_front()));
            len_r = 0;
        end
        if (write) begin
            if (wpos % BC == 0) begin
                if (q_bits.size() == 0) miss("dout_bit", wpos);
                else cur = q_bits.pop_front();
            end
            chk("dout", 32'(dout), 32'(cur));
            wpos++;
        end else wpos = 0;
        if (l_rdy) begin
            if (q_adj.size() == 0) miss("adj", 0);
            else begin
                e_adj = q_adj.pop_front();
                chk("adj_eff", 32'(RECEIVED_EFF), 32'(e_adj[16:9]));
                chk("adj_pow", 32'(RECEIVED_POWER_RX), 32'(e_adj[8:1]));
                chk("adj_updown", 32'(l_up_down), 32'(e_adj[0]));
            end
            chk("adj_windows", 32'({read, write}), 32'(0));
        end
    end

    task automatic push_round(input int wlen, input int rlen, input logic do_adj, input logic [16:0] adj);
        logic [151:0] f;
        f = {8'hA5, w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};
        q_meas.push_back(MC);
        q_write.push_back(wlen);
        for (int i = 0; i < (wlen + BC - 1) / BC; i++) q_bits.push_back(f[151-i]);
        if (rlen > 0) q_read.push_back(rlen);
        if (do_adj) q_adj.push_back(adj);
    endtask

    task automatic wait_high(input logic want_read, input string name);
        int n;
        n = 0;
        while ((want_read ? read : write) !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: window never opened, got timeout expected window", name);
        end
    endtask

    task automatic drive_rx(input logic [15:0] v);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b = v[15-i];
            for (int c = 0; c < BC; c++) begin
                ADC = b ? ((i % 2 == 1) ? p1b[c] : p1a[c]) : ((i % 2 == 1) ? p0b[c] : p0a[c]);
                @(posedge clk);
                #1;
            end
        end
        ADC = '0;
    endtask

    initial begin
        w = '{16'h8001, 16'h0032, 16'h00C8, 16'h0041, 16'h0100, 16'h0010, 16'h0003, 16'h0007, 16'h012C};
        prog = 2'b11;
        swiptAlive = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({read, write, dout, l_rdy, l_up_down, getMeanCurrent}), 32'(0));
        chk("rst_eff", 32'(RECEIVED_EFF), 32'(0));
        chk("rst_pow", 32'(RECEIVED_POWER_RX), 32'(0));
        push_round(152 * BC, 16 * BC, 1'b1, {8'h3C, 8'h90, 1'b1});
        nrst = 1'b1;
        wait_high(1'b0, "write1");
        repeat (10) @(posedge clk);
        #1;
        w[0] = 16'h1234;
        wait_high(1'b1, "read1");
        drive_rx(16'h3C90);
        push_round(152 * BC, 16 * BC, 1'b1, {8'h5A, 8'h80, 1'b0});
        wait_high(1'b1, "read2");
        drive_rx(16'h5A80);
        push_round(152 * BC, 21, 1'b0, '0);
        wait_high(1'b1, "read3");
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        swiptAlive = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_windows", 32'({read, write, getMeanCurrent, l_rdy}), 32'(0));
        chk("abort_eff", 32'(RECEIVED_EFF), 32'(8'h5A));
        chk("abort_pow", 32'(RECEIVED_POWER_RX), 32'(8'h80));
        push_round(51, 0, 1'b0, '0);
        swiptAlive = 1'b1;
        wait_high(1'b0, "write4");
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("midtx_rst_outputs", 32'({read, write, dout, l_rdy, l_up_down, getMeanCurrent}), 32'(0));
        chk("midtx_rst_eff", 32'(RECEIVED_EFF), 32'(0));
        chk("midtx_rst_pow", 32'(RECEIVED_POWER_RX), 32'(0));
        prog = 2'b00;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold", 32'({read, write, getMeanCurrent}), 32'(0));
        chk("queues_drained", 32'(q_meas.size() + q_write.size() + q_read.size() + q_bits.size() + q_adj.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
